// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control slice: opcodes, functs, ALU selects, FSM states.
// Pure declarations; no logic, no latency, no flow control.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SRLV = 6'b000110;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SRLV = 3'b011;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    // State register is kept as a plain vector so encodings stay fixed for existing tooling.
    typedef logic [3:0] state_t;

    localparam state_t S_FETCH    = 4'd0;
    localparam state_t S_DECODE   = 4'd1;
    localparam state_t S_MEMADR   = 4'd2;
    localparam state_t S_MEMREAD  = 4'd3;
    localparam state_t S_MEMWB    = 4'd4;
    localparam state_t S_MEMWRITE = 4'd5;
    localparam state_t S_EXECUTE  = 4'd6;
    localparam state_t S_ALUWB    = 4'd7;
    localparam state_t S_BRANCH   = 4'd8;
    localparam state_t S_ADDIEX   = 4'd9;
    localparam state_t S_ADDIWB   = 4'd10;
    localparam state_t S_JUMP     = 4'd11;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: maps (alu_op, funct) onto the 3-bit ALU select and flags unsupported functs.
// Purely combinational, zero latency; no backpressure.
module alu_decoder
    import mips_pkg::*;
(
    input  alu_op_e    alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_sel,
    output logic       bad_funct
);

    always_comb begin
        alu_sel   = ALU_ADD;
        bad_funct = 1'b0;
        case (alu_op)
            ALUOP_SUB:   alu_sel = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_sel = ALU_ADD;
                    FN_SUB:  alu_sel = ALU_SUB;
                    FN_AND:  alu_sel = ALU_AND;
                    FN_OR:   alu_sel = ALU_OR;
                    FN_SLT:  alu_sel = ALU_SLT;
                    FN_SRLV: alu_sel = ALU_SRLV;
                    default: bad_funct = 1'b1;   // select stays ADD, harmless with no writeback
                endcase
            end
            default:     alu_sel = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_control_fsm.sv
// Multicycle MIPS main control: Moore FSM over instruction phases driving datapath selects/enables.
// Latency FETCH->FETCH: lw 5, sw/R/addi 4, beq/j 3; no backpressure. MIPS_BNE_EN adds bne support.
module mips_control_fsm
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [2:0] alu_sel,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       iord,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       pc_en,
    output logic       illegal
);

    state_t  state;
    state_t  state_nxt;
    alu_op_e alu_op;
    logic    bad_funct;
    logic    pc_write;
    logic    branch;
    logic    branch_take;
    logic    ir_write_s;
    logic    mem_write_s;
    logic    reg_write_s;
    logic    illegal_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // alu_op depends on state only, keeping the decoder out of the next-state loop.
    always_comb begin
        alu_op = ALUOP_ADD;
        if (state == S_EXECUTE) begin
            alu_op = ALUOP_FUNCT;
        end else if (state == S_BRANCH) begin
            alu_op = ALUOP_SUB;
        end
    end

    alu_decoder u_alu_decoder (
        .alu_op    (alu_op),
        .funct     (funct),
        .alu_sel   (alu_sel),
        .bad_funct (bad_funct)
    );

    always_comb begin
        state_nxt   = S_FETCH;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        pc_src      = 2'b00;
        iord        = 1'b0;
        mem_to_reg  = 1'b0;
        reg_dst     = 1'b0;
        ir_write_s  = 1'b0;
        mem_write_s = 1'b0;
        reg_write_s = 1'b0;
        pc_write    = 1'b0;
        branch      = 1'b0;
        illegal_s   = 1'b0;
        case (state)
            S_FETCH: begin
                ir_write_s = 1'b1;
                pc_write   = 1'b1;
                alu_src_b  = 2'b01;
                state_nxt  = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_RTYPE:     state_nxt = S_EXECUTE;
                    OP_BEQ:       state_nxt = S_BRANCH;
`ifdef MIPS_BNE_EN
                    OP_BNE:       state_nxt = S_BRANCH;
`endif
                    OP_ADDI:      state_nxt = S_ADDIEX;
                    OP_J:         state_nxt = S_JUMP;
                    default:      illegal_s = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (opcode == OP_LW) begin
                    state_nxt = S_MEMREAD;
                end else if (opcode == OP_SW) begin
                    state_nxt = S_MEMWRITE;
                end
            end
            S_MEMREAD: begin
                iord      = 1'b1;
                state_nxt = S_MEMWB;
            end
            S_MEMWB: begin
                mem_to_reg  = 1'b1;
                reg_write_s = 1'b1;
            end
            S_MEMWRITE: begin
                iord        = 1'b1;
                mem_write_s = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                if (bad_funct) begin
                    illegal_s = 1'b1;
                end else begin
                    state_nxt = S_ALUWB;
                end
            end
            S_ALUWB: begin
                reg_dst     = 1'b1;
                reg_write_s = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                pc_src    = 2'b01;
                branch    = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_nxt = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write_s = 1'b1;
            end
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: state_nxt = S_FETCH;
        endcase
    end

`ifdef MIPS_BNE_EN
    logic is_bne;
    assign is_bne      = (opcode == OP_BNE);
    assign branch_take = branch & (zero ^ is_bne);
`else
    assign branch_take = branch & zero;
`endif

    // Enables are gated by rst_n directly so nothing writes once reset falls, even mid-cycle.
    assign ir_write  = ir_write_s  & rst_n;
    assign mem_write = mem_write_s & rst_n;
    assign reg_write = reg_write_s & rst_n;
    assign pc_en     = (pc_write | branch_take) & rst_n;
    assign illegal   = illegal_s   & rst_n;

endmodule
